vga_timing_gen: RTL

Pixel-domain raster timing generator for the 1280x1024@60 Hz VGA output. Clocked by the 108 MHz clock produced by the VGA PLL. Consumes the PLL `locked` flag, waits a settle interval, then produces hsync/vsync/blank/data-enable and pixel coordinates for the frame-buffer reader and DAC. Loss of lock stops the raster cleanly, and the raster restarts from pixel (0,0) once lock is regained.

---
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: lock synchronizer, IDLE/SETTLE/RUN sequencer, h/v counters and registered sync/DE decodes.
// Optional macro VGA_TIMING_RAM_ALIGN_EN delays the decodes one cycle behind hcount/vcount for a synchronous frame-buffer read.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BP      = 248,
  parameter int V_ACTIVE  = 1024,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 38,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int LOCK_WAIT = 1024,
  parameter int CNT_W     = 11
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             blank_n,
  output logic             frame_start,
  output logic             running
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int SET_W    = $clog2(LOCK_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sync_1;
  logic             lock_s;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             run_nxt;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             de_nxt;
  logic             fs_nxt;

  // Decodes look at the counter values that will be presented next cycle,
  // so every output stays a plain register.
  always_comb begin
    state_nxt = state;
    if (!lock_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_SETTLE;
        ST_SETTLE: if (settle_cnt == SET_W'(LOCK_WAIT - 1)) state_nxt = ST_RUN;
        default:   state_nxt = state;
      endcase
    end

    run_nxt = (state_nxt == ST_RUN);
    h_nxt   = '0;
    v_nxt   = '0;
    if (run_nxt && state == ST_RUN) begin
      if (hcount == CNT_W'(H_TOTAL - 1)) begin
        h_nxt = '0;
        v_nxt = (vcount == CNT_W'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
      end else begin
        h_nxt = hcount + 1'b1;
        v_nxt = vcount;
      end
    end

    hs_nxt = run_nxt && (h_nxt >= CNT_W'(HS_START)) && (h_nxt <= CNT_W'(HS_END));
    vs_nxt = run_nxt && (v_nxt >= CNT_W'(VS_START)) && (v_nxt <= CNT_W'(VS_END));
    de_nxt = run_nxt && (h_nxt < CNT_W'(H_ACTIVE)) && (v_nxt < CNT_W'(V_ACTIVE));
    fs_nxt = run_nxt && (h_nxt == '0) && (v_nxt == '0);
  end

`ifdef VGA_TIMING_RAM_ALIGN_EN
  logic hs_d;
  logic vs_d;
  logic de_d;
  logic fs_d;
`endif

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_1      <= 1'b0;
      lock_s      <= 1'b0;
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      de          <= 1'b0;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
`ifdef VGA_TIMING_RAM_ALIGN_EN
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      de_d        <= 1'b0;
      fs_d        <= 1'b0;
`endif
    end else begin
      sync_1     <= locked;
      lock_s     <= sync_1;
      state      <= state_nxt;
      // Held at zero outside SETTLE, so every entry into SETTLE counts from 0.
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      hcount     <= h_nxt;
      vcount     <= v_nxt;
      running    <= run_nxt;
`ifdef VGA_TIMING_RAM_ALIGN_EN
      hs_d        <= hs_nxt;
      vs_d        <= vs_nxt;
      de_d        <= de_nxt;
      fs_d        <= fs_nxt;
      // Gating with run_nxt drops the in-flight stage as soon as RUN is left.
      hsync       <= (run_nxt && hs_d) ? HS_POL : !HS_POL;
      vsync       <= (run_nxt && vs_d) ? VS_POL : !VS_POL;
      de          <= run_nxt && de_d;
      blank_n     <= run_nxt && de_d;
      frame_start <= run_nxt && fs_d;
`else
      hsync       <= hs_nxt ? HS_POL : !HS_POL;
      vsync       <= vs_nxt ? VS_POL : !VS_POL;
      de          <= de_nxt;
      blank_n     <= de_nxt;
      frame_start <= fs_nxt;
`endif
    end
  end

endmodule
